// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//   Shares one external combinational ALU between NREQ requesters. Each cycle a
//   round-robin arbiter grants at most one valid request. The granted operands
//   and op code are muxed onto the ALU ports. The ALU result is captured in a
//   one-deep response register that is tagged with the requester index.
//
// Parameters
//   NREQ  number of requesters (2..4)
//   ID_W  width of resp_id, equal to $clog2(NREQ)
//
// Ports
//   clk, rstn            clock and asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot)
//   req_a/b/c/pattern    packed per-requester operands, op code and shamt
//   alu_a/b/c/pattern    drive to the shared ALU (all zero when nothing is granted)
//   alu_out              combinational result returned by the ALU
//   flush                synchronous drop of the pending response
//   resp_valid/ready     response handshake
//   resp_data, resp_id   registered result and the index of its requester
//   resp_err             present only when ALU_ILLEGAL_CHK_EN is defined
//
// Optional feature
//   ALU_ILLEGAL_CHK_EN: when defined, a granted op code above 9 is still
//   accepted. Its response carries resp_data=0 and resp_err=1.
// -----------------------------------------------------------------------------
module alu_share_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ*5-1:0]  req_c,
  input  logic [NREQ*4-1:0]  req_pattern,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [4:0]         alu_c,
  output logic [3:0]         alu_pattern,
  input  logic [31:0]        alu_out,
  input  logic               flush,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_data,
  output logic [ID_W-1:0]    resp_id
`ifdef ALU_ILLEGAL_CHK_EN
  ,
  output logic               resp_err
`endif
);

  logic [ID_W-1:0] r_ptr;
  logic            r_valid;
  logic [31:0]     r_data;
  logic [ID_W-1:0] r_id;

  logic            w_found;
  logic [ID_W-1:0] w_idx;
  logic            w_can_issue;
  logic            w_grant;
  logic [31:0]     w_result;

  // Round-robin search. The first pass looks at indices above the last
  // winner. The second pass wraps around to indices at or below it. Searching
  // this way avoids a modulo and avoids a variable bit select.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i] && (i > int'(r_ptr))) begin
        w_found = 1'b1;
        w_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i] && (i <= int'(r_ptr))) begin
        w_found = 1'b1;
        w_idx   = ID_W'(i);
      end
    end
  end

  // A new result may enter only when the response slot is empty or is being
  // drained this cycle. The rstn term keeps req_ready low while reset is held.
  assign w_can_issue = !r_valid || resp_ready;
  assign w_grant     = w_found && w_can_issue && !flush && rstn;

  always_comb begin
    req_ready   = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_c       = '0;
    alu_pattern = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant && (w_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        alu_a        = req_a[32*i +: 32];
        alu_b        = req_b[32*i +: 32];
        alu_c        = req_c[5*i +: 5];
        alu_pattern  = req_pattern[4*i +: 4];
      end
    end
  end

`ifdef ALU_ILLEGAL_CHK_EN
  logic w_illegal;
  logic r_err;
  assign w_illegal = (alu_pattern > 4'd9);
  assign w_result  = w_illegal ? 32'd0 : alu_out;
`else
  assign w_result  = alu_out;
`endif

  // Response register. When no grant occurs, the data and id hold their last
  // values and only the valid bit changes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr   <= ID_W'(NREQ - 1);
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
`ifdef ALU_ILLEGAL_CHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_grant) begin
        r_valid <= 1'b1;
        r_data  <= w_result;
        r_id    <= w_idx;
        r_ptr   <= w_idx;
`ifdef ALU_ILLEGAL_CHK_EN
        r_err   <= w_illegal;
`endif
      end else if (resp_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign resp_valid = r_valid;
  assign resp_data  = r_data;
  assign resp_id    = r_id;
`ifdef ALU_ILLEGAL_CHK_EN
  assign resp_err   = r_err;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
//   Directed bench for alu_share_arb with NREQ=2. A small behavioural ALU is
//   wired to the alu_* ports. When a grant is expected, the bench pushes the
//   result computed from the requester's own operands onto a scoreboard queue.
//   It pops that entry after the clock edge and compares it with the response
//   register.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;

  localparam int NREQ = 2;
  localparam int ID_W = 1;

  typedef struct {
    logic [31:0] d;
    logic [0:0]  id;
    logic        err;
  } sb_t;

  logic              clk;
  logic              rstn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*5-1:0]  req_c;
  logic [NREQ*4-1:0]  req_pattern;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [4:0]        alu_c;
  logic [3:0]        alu_pattern;
  logic [31:0]       alu_out;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic [ID_W-1:0]   resp_id;
`ifdef ALU_ILLEGAL_CHK_EN
  logic              resp_err;
`endif

  logic [31:0] a_in [NREQ];
  logic [31:0] b_in [NREQ];
  logic [3:0]  p_in [NREQ];

  sb_t         sbq [$];
  logic        m_valid;
  logic [31:0] m_data;
  logic [0:0]  m_id;
  logic        m_err;

  int checks;
  int errors;

  assign req_a       = {a_in[1], a_in[0]};
  assign req_b       = {b_in[1], b_in[0]};
  assign req_c       = '0;
  assign req_pattern = {p_in[1], p_in[0]};

  alu_share_arb #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_c       (req_c),
    .req_pattern (req_pattern),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c),
    .alu_pattern (alu_pattern),
    .alu_out     (alu_out),
    .flush       (flush),
`ifdef ALU_ILLEGAL_CHK_EN
    .resp_err    (resp_err),
`endif
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_id     (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 1 add, 2 and, 4 shift-left b by a, 6 subtract, else 0.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] p);
    case (p)
      4'd1:    alu_fn = a + b;
      4'd2:    alu_fn = a & b;
      4'd4:    alu_fn = b << a[4:0];
      4'd6:    alu_fn = a - b;
      default: alu_fn = 32'd0;
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_a, alu_b, alu_pattern);

  function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] p);
`ifdef ALU_ILLEGAL_CHK_EN
    if (p > 4'd9) return 32'd0;
`endif
    return alu_fn(a, b, p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef ALU_ILLEGAL_CHK_EN
    chk("rst_resp_err", 32'(resp_err), 32'd0);
`endif
  endtask

  // Runs one clock with the inputs already driven. Before the edge it checks
  // the grant and ALU drive. After the edge it checks the response register
  // against the model.
  task automatic step(input string tag, input logic [1:0] exp_rdy);
    sb_t e;
    int  g;
    #1;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(exp_rdy));
    g = -1;
    if (exp_rdy == 2'b01) g = 0;
    else if (exp_rdy == 2'b10) g = 1;
    if (g >= 0) begin
      chk({tag, "_alu_a"}, alu_a, a_in[g]);
      chk({tag, "_alu_pattern"}, 32'(alu_pattern), 32'(p_in[g]));
      e.d   = exp_result(a_in[g], b_in[g], p_in[g]);
      e.id  = g[0:0];
      e.err = (p_in[g] > 4'd9);
      sbq.push_back(e);
    end else begin
      chk({tag, "_alu_idle"}, alu_a | alu_b | 32'(alu_pattern), 32'd0);
    end
    @(posedge clk);
    #1;
    if (flush) begin
      m_valid = 1'b0;
    end else if (g >= 0) begin
      e       = sbq.pop_front();
      m_valid = 1'b1;
      m_data  = e.d;
      m_id    = e.id;
      m_err   = e.err;
    end else if (resp_ready) begin
      m_valid = 1'b0;
    end
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(m_valid));
    chk({tag, "_resp_data"}, resp_data, m_data);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'(m_id));
`ifdef ALU_ILLEGAL_CHK_EN
    chk({tag, "_resp_err"}, 32'(resp_err), 32'(m_err));
`endif
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_id       = '0;
    m_err      = 1'b0;
    rstn       = 1'b0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 2'b11;
    for (int i = 0; i < NREQ; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
      p_in[i] = '0;
    end

    // Reset held: everything quiet even with requests pending.
    #12;
    chk_reset_state();
    @(negedge clk);
    rstn = 1'b1;

    // Single operations on requester 0.
    req_valid = 2'b01;
    a_in[0] = 32'd5; b_in[0] = 32'd7; p_in[0] = 4'd1;
    step("add", 2'b01);
    chk("add_value", resp_data, 32'd12);
    a_in[0] = 32'd3; b_in[0] = 32'd5; p_in[0] = 4'd6;
    step("sub", 2'b01);
    chk("sub_value", resp_data, 32'hFFFF_FFFE);
    a_in[0] = 32'd4; b_in[0] = 32'd1; p_in[0] = 4'd4;
    step("shl", 2'b01);
    chk("shl_value", resp_data, 32'd16);

    // A lone requester 1 moves the pointer so fairness starts at 0.
    req_valid = 2'b10;
    a_in[1] = 32'd20; b_in[1] = 32'd2; p_in[1] = 4'd6;
    step("solo1", 2'b10);

    // Fairness: both requesting, grants alternate 0,1,0,1,0,1.
    a_in[0] = 32'd10; b_in[0] = 32'd1; p_in[0] = 4'd1;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      step("rr0", 2'b01);
      step("rr1", 2'b10);
    end

    // Backpressure: no grants, response held.
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) step("bp", 2'b00);
    resp_ready = 1'b1;
    a_in[0] = 32'h0F0F_00FF; b_in[0] = 32'h00FF_0F0F; p_in[0] = 4'd2;
    step("bp_release", 2'b01);

    // Flush while the response is stalled.
    resp_ready = 1'b0;
    flush      = 1'b1;
    step("flush", 2'b00);
    flush      = 1'b0;
    resp_ready = 1'b1;
    step("post_flush", 2'b10);

    // Drain with no requests: valid drops, data and id retained.
    req_valid = 2'b00;
    step("drain", 2'b00);

    // Asynchronous reset mid-stream while a response is valid.
    req_valid = 2'b01;
    step("pre_rst", 2'b01);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_state();
    m_valid = 1'b0; m_data = '0; m_id = '0; m_err = 1'b0;
    sbq.delete();
    @(negedge clk);
    rstn = 1'b1;
    req_valid = 2'b11;
    a_in[1] = 32'd9; b_in[1] = 32'd9; p_in[1] = 4'd1;
    step("rst_first", 2'b01);
    step("rst_second", 2'b10);

    // Illegal op code: accepted, result forced to zero (error flag when enabled).
    req_valid = 2'b01;
    a_in[0] = 32'd5; b_in[0] = 32'd6; p_in[0] = 4'd12;
    step("illegal", 2'b01);
    chk("illegal_data", resp_data, 32'd0);
    a_in[0] = 32'hFFFF_0000; b_in[0] = 32'h1234_5678; p_in[0] = 4'd2;
    step("legal", 2'b01);
    chk("legal_data", resp_data, 32'h1234_0000);

    req_valid = 2'b00;
    step("idle", 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
